// File: rtl/rv32i_mem_arbiter.sv
// Shares one memory port between rv32i fetch and load/store; ARB_STARVE_GUARD_EN caps data runs while a fetch waits.
// Latency: o_mem_req one cycle after request sampled; requester ack one cycle after i_mem_ack; 3 cycles minimum per transaction.
// Backpressure: requesters hold req until ack; o_mem_* held stable until i_mem_ack; losing requester simply waits.
module rv32i_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_inst_req,
    input  logic [ADDR_W-1:0] i_inst_addr,
    output logic              o_inst_ack,
    output logic [31:0]       o_inst_rdata,
    input  logic              i_data_req,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic              i_data_wr_en,
    input  logic [3:0]        i_data_wr_mask,
    input  logic [31:0]       i_data_wdata,
    output logic              o_data_ack,
    output logic [31:0]       o_data_rdata,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wr_en,
    output logic [3:0]        o_mem_wr_mask,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [31:0]       i_mem_rdata,
    output logic [1:0]        o_grant,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_INST = 2'b01;
    localparam logic [1:0] GNT_DATA = 2'b10;

    if (MAX_DATA_RUN < 1) begin : g_bad_run
        $error("MAX_DATA_RUN must be at least 1");
    end

    state_t state;
    logic   pick_inst;

`ifdef ARB_STARVE_GUARD_EN
    localparam int RUN_W = ($clog2(MAX_DATA_RUN + 1) < 3) ? 3 : $clog2(MAX_DATA_RUN + 1);

    logic [RUN_W-1:0] run_cnt;
    logic             starve;

    assign starve    = i_inst_req && (run_cnt >= RUN_W'(MAX_DATA_RUN));
    assign pick_inst = i_inst_req && (!i_data_req || starve);

    // Counts data grants that overtook a waiting fetch; only IDLE cycles matter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            run_cnt <= '0;
        end else if (state == IDLE) begin
            if (!i_inst_req || pick_inst) begin
                run_cnt <= '0;
            end else if (i_data_req && (run_cnt != '1)) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end
`else
    assign pick_inst = i_inst_req && !i_data_req;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            o_grant       <= GNT_NONE;
            o_busy        <= 1'b0;
            o_mem_req     <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wr_en   <= 1'b0;
            o_mem_wr_mask <= 4'b0;
            o_mem_wdata   <= 32'b0;
            o_inst_ack    <= 1'b0;
            o_data_ack    <= 1'b0;
            o_inst_rdata  <= 32'b0;
            o_data_rdata  <= 32'b0;
        end else begin
            o_inst_ack <= 1'b0;
            o_data_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_inst_req || i_data_req) begin
                        state     <= BUSY;
                        o_busy    <= 1'b1;
                        o_mem_req <= 1'b1;
                        if (pick_inst) begin
                            o_grant       <= GNT_INST;
                            o_mem_addr    <= i_inst_addr;
                            o_mem_wr_en   <= 1'b0;
                            o_mem_wr_mask <= 4'b0;
                            o_mem_wdata   <= 32'b0;
                        end else begin
                            o_grant       <= GNT_DATA;
                            o_mem_addr    <= i_data_addr;
                            o_mem_wr_en   <= i_data_wr_en;
                            o_mem_wr_mask <= i_data_wr_mask;
                            o_mem_wdata   <= i_data_wdata;
                        end
                    end
                end
                BUSY: begin
                    if (i_mem_ack) begin
                        state     <= RESP;
                        o_mem_req <= 1'b0;
                        // Ack is raised on entry so it is high for exactly the RESP cycle.
                        if (o_grant == GNT_INST) begin
                            o_inst_rdata <= i_mem_rdata;
                            o_inst_ack   <= 1'b1;
                        end else begin
                            o_data_rdata <= i_mem_rdata;
                            o_data_ack   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    o_busy  <= 1'b0;
                    o_grant <= GNT_NONE;
                end
                default: begin
                    state   <= IDLE;
                    o_busy  <= 1'b0;
                    o_grant <= GNT_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Randomized scoreboard bench for rv32i_mem_arbiter; reference model predicts winners, memory traffic and acks.
module tb_rv32i_mem_arbiter;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int MAX_RUN = 4;
    localparam int OWN_I = 1;
    localparam int OWN_D = 2;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_inst_req;
    logic [31:0] i_inst_addr;
    logic        o_inst_ack;
    logic [31:0] o_inst_rdata;
    logic        i_data_req;
    logic [31:0] i_data_addr;
    logic        i_data_wr_en;
    logic [3:0]  i_data_wr_mask;
    logic [31:0] i_data_wdata;
    logic        o_data_ack;
    logic [31:0] o_data_rdata;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        o_mem_wr_en;
    logic [3:0]  o_mem_wr_mask;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic [1:0]  o_grant;
    logic        o_busy;

    rv32i_mem_arbiter #(.ADDR_W(32), .MAX_DATA_RUN(MAX_RUN)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr),
        .o_inst_ack(o_inst_ack), .o_inst_rdata(o_inst_rdata),
        .i_data_req(i_data_req), .i_data_addr(i_data_addr),
        .i_data_wr_en(i_data_wr_en), .i_data_wr_mask(i_data_wr_mask),
        .i_data_wdata(i_data_wdata), .o_data_ack(o_data_ack),
        .o_data_rdata(o_data_rdata), .o_mem_req(o_mem_req),
        .o_mem_addr(o_mem_addr), .o_mem_wr_en(o_mem_wr_en),
        .o_mem_wr_mask(o_mem_wr_mask), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_grant(o_grant), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          owner;
        logic [31:0] addr;
        logic        wr_en;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } mtx_t;

    typedef struct {
        int          owner;
        logic [31:0] rdata;
    } rsp_t;

    mtx_t mem_q[$];
    rsp_t resp_q[$];
    int   grant_log[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- reference model (sampled at the active edge) ----------------
    // phase: 0 = arbiter free, 1 = memory access outstanding, 2 = response cycle
    int          phase = 0;
    int          owner = 0;
    int          passed_over = 0;
    logic [31:0] exp_inst_rdata = 32'h0;
    logic [31:0] exp_data_rdata = 32'h0;
    mtx_t        mt;
    rsp_t        rt;

    always @(posedge i_clk) begin
        if (i_rst) begin
            phase = 0; owner = 0; passed_over = 0;
            exp_inst_rdata = 32'h0; exp_data_rdata = 32'h0;
            resp_q.delete();
        end else if (phase == 0) begin
            if (!i_inst_req) passed_over = 0;
            if (i_inst_req || i_data_req) begin
                // Data wins, unless the fetch has already been overtaken MAX_RUN times in a row.
                if (i_data_req && !(GUARD && i_inst_req && passed_over >= MAX_RUN)) begin
                    mt = '{OWN_D, i_data_addr, i_data_wr_en, i_data_wr_mask, i_data_wdata};
                    if (i_inst_req) passed_over++;
                end else begin
                    mt = '{OWN_I, i_inst_addr, 1'b0, 4'h0, 32'h0};
                    passed_over = 0;
                end
                owner = mt.owner;
                mem_q.push_back(mt);
                phase = 1;
            end
        end else if (phase == 1) begin
            if (i_mem_ack) begin
                rt = '{owner, i_mem_rdata};
                resp_q.push_back(rt);
                if (owner == OWN_I) exp_inst_rdata = i_mem_rdata;
                else exp_data_rdata = i_mem_rdata;
                phase = 2;
            end
        end else begin
            phase = 0;
            owner = 0;
        end
    end

    // ---------------- memory responder ----------------
    bit          mem_auto = 1'b1;
    bit          spur_en = 1'b0;
    int          lat_cfg = 0;
    bit          rdata_forced = 1'b0;
    logic [31:0] rdata_cfg = 32'h0;
    int          stray_req_cnt = 0;
    int          stray_done_cnt = 0;
    bit          tx_act = 1'b0;
    int          tx_cnt = 0;
    int          tx_lat = 1;

    initial begin
        i_mem_ack = 1'b0;
        i_mem_rdata = 32'h0;
        forever begin
            @(negedge i_clk);
            if (i_rst) tx_act = 1'b0;
            if (i_mem_ack) begin
                i_mem_ack = 1'b0;
            end else if (stray_done_cnt != stray_req_cnt) begin
                i_mem_ack = 1'b1;
                i_mem_rdata = $urandom;
                stray_done_cnt++;
            end else if (mem_auto && !i_rst) begin
                if (o_mem_req) begin
                    if (!tx_act) begin
                        tx_act = 1'b1;
                        tx_cnt = 0;
                        tx_lat = (lat_cfg != 0) ? lat_cfg : $urandom_range(1, 4);
                    end
                    tx_cnt++;
                    if (tx_cnt >= tx_lat) begin
                        i_mem_ack = 1'b1;
                        i_mem_rdata = rdata_forced ? rdata_cfg : $urandom;
                        tx_act = 1'b0;
                    end
                end else if (spur_en && $urandom_range(0, 9) == 0) begin
                    i_mem_ack = 1'b1;
                    i_mem_rdata = $urandom;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit   mon_on = 1'b0;
    logic prev_mem_req = 1'b0;
    mtx_t cur;
    rsp_t got;

    always @(negedge i_clk) begin
        if (mon_on) begin
            chk("busy", {31'b0, o_busy}, (phase != 0) ? 32'd1 : 32'd0);
            chk("grant", {30'b0, o_grant}, (phase == 0) ? 32'd0 : owner);
            chk("mem_req", {31'b0, o_mem_req}, (phase == 1) ? 32'd1 : 32'd0);
            chk("inst_ack", {31'b0, o_inst_ack}, (phase == 2 && owner == OWN_I) ? 32'd1 : 32'd0);
            chk("data_ack", {31'b0, o_data_ack}, (phase == 2 && owner == OWN_D) ? 32'd1 : 32'd0);
            chk("inst_rdata_hold", o_inst_rdata, exp_inst_rdata);
            chk("data_rdata_hold", o_data_rdata, exp_data_rdata);
            if (o_mem_req && !prev_mem_req) begin
                if (mem_q.size() == 0) fail_now("mem_issue_unexpected");
                else begin
                    cur = mem_q.pop_front();
                    grant_log.push_back(int'(o_grant));
                end
            end
            if (o_mem_req) begin
                chk("mem_addr", o_mem_addr, cur.addr);
                chk("mem_wr_en", {31'b0, o_mem_wr_en}, {31'b0, cur.wr_en});
                chk("mem_wr_mask", {28'b0, o_mem_wr_mask}, {28'b0, cur.mask});
                if (cur.owner == OWN_D) chk("mem_wdata", o_mem_wdata, cur.wdata);
            end
            if (o_inst_ack || o_data_ack) begin
                if (resp_q.size() == 0) fail_now("ack_unexpected");
                else begin
                    got = resp_q.pop_front();
                    chk("ack_owner", o_inst_ack ? 32'd1 : 32'd2, got.owner);
                    chk("ack_rdata", o_inst_ack ? o_inst_rdata : o_data_rdata, got.rdata);
                end
            end
            prev_mem_req = o_mem_req;
        end
    end

    // ---------------- requester drivers ----------------
    task automatic inst_txn(input logic [31:0] a);
        int n = 0;
        i_inst_req = 1'b1;
        i_inst_addr = a;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_inst_ack && n < 400);
        if (!o_inst_ack) fail_now("inst_ack_timeout");
        i_inst_req = 1'b0;
    endtask

    task automatic data_txn(input logic [31:0] a, input logic we, input logic [3:0] m,
                            input logic [31:0] wd, input bit keep, input bit drop);
        int n = 0;
        i_data_req = 1'b1;
        i_data_addr = a;
        i_data_wr_en = we;
        i_data_wr_mask = m;
        i_data_wdata = wd;
        do begin
            @(negedge i_clk);
            n++;
            if (drop && o_grant == 2'b10 && !o_data_ack) i_data_req = 1'b0;
        end while (!o_data_ack && n < 400);
        if (!o_data_ack) fail_now("data_ack_timeout");
        if (!keep) i_data_req = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        i_rst = 1'b1;
        i_inst_req = 1'b0; i_inst_addr = 32'h0;
        i_data_req = 1'b0; i_data_addr = 32'h0;
        i_data_wr_en = 1'b0; i_data_wr_mask = 4'h0; i_data_wdata = 32'h0;
        idle_cycles(3);
        mon_on = 1'b1;
        chk("rst_mem_addr", o_mem_addr, 32'h0);
        chk("rst_mem_wdata", o_mem_wdata, 32'h0);
        chk("rst_mem_mask", {28'b0, o_mem_wr_mask}, 32'h0);
        i_rst = 1'b0;
        idle_cycles(2);

        // single fetch, memory latency 1
        lat_cfg = 1; rdata_forced = 1'b1; rdata_cfg = 32'h00A00093;
        inst_txn(32'h0000_0010);
        chk("fetch_rdata", o_inst_rdata, 32'h00A00093);
        rdata_forced = 1'b0;
        idle_cycles(2);

        // store, memory latency 3
        lat_cfg = 3;
        data_txn(32'h0000_1080, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1'b0, 1'b0);
        lat_cfg = 0;
        idle_cycles(2);

        // simultaneous fetch and load: data first
        grant_log.delete();
        fork
            inst_txn(32'h0000_0020);
            data_txn(32'h0000_1084, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
        join
        idle_cycles(2);
        chk("simul_order_len", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("simul_first", grant_log[0], OWN_D);
            chk("simul_second", grant_log[1], OWN_I);
        end

        // reset while BUSY, then a stray memory ack
        mem_auto = 1'b0;
        i_inst_req = 1'b1; i_inst_addr = 32'h0000_0040;
        idle_cycles(2);
        chk("busy_before_rst", {31'b0, o_mem_req}, 32'd1);
        i_rst = 1'b1; i_inst_req = 1'b0;
        idle_cycles(1);
        chk("rst_drops_mem_req", {31'b0, o_mem_req}, 32'd0);
        i_rst = 1'b0;
        stray_req_cnt++;
        idle_cycles(4);

        // spurious memory ack while idle
        stray_req_cnt++;
        idle_cycles(3);
        chk("spur_idle_busy", {31'b0, o_busy}, 32'd0);
        mem_auto = 1'b1;

        // continuous data traffic against one waiting fetch
        grant_log.delete();
        fork
            inst_txn(32'h0000_0100);
            begin
                for (int k = 0; k < 20; k++)
                    data_txn({16'h0000, 16'($urandom) & 16'hFFFC}, 1'($urandom), 4'($urandom),
                             $urandom, 1'b1, 1'b0);
                i_data_req = 1'b0;
            end
        join
        idle_cycles(3);
        chk("starve_len", grant_log.size(), 21);
        for (int k = 0; k < grant_log.size(); k++)
            chk($sformatf("starve_grant_%0d", k), grant_log[k],
                (k == (GUARD ? MAX_RUN : 20)) ? OWN_I : OWN_D);

        // randomized mixed traffic with spurious acks and early req drops
        spur_en = 1'b1;
        fork
            for (int k = 0; k < 30; k++) begin
                idle_cycles($urandom_range(0, 3));
                inst_txn($urandom);
            end
            for (int k = 0; k < 30; k++) begin
                idle_cycles($urandom_range(0, 2));
                data_txn($urandom, 1'($urandom), 4'($urandom), $urandom, 1'b0,
                         ($urandom_range(0, 3) == 0));
            end
        join
        spur_en = 1'b0;
        idle_cycles(6);

        chk("mem_q_drained", mem_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
Shares the single-ported unified memory between the rv32i core's instruction-fetch port and its load/store port. Requests are accepted on a req/ack handshake, one transaction at a time is forwarded to the memory, and the read data or acknowledge is routed back to the requester that was granted. It sits between the core and the memory inside the SoC top level.

Parameters:
- ADDR_W, 32, address width on all ports.
- MAX_DATA_RUN, 4, number of consecutive data grants allowed while a fetch is pending (used only with the optional feature).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_inst_req  in  1  fetch request, held until o_inst_ack
- i_inst_addr  in  ADDR_W  fetch byte address
- o_inst_ack  out  1  one-cycle pulse, fetch complete
- o_inst_rdata  out  32  fetched word, valid with o_inst_ack
- i_data_req  in  1  load/store request, held until o_data_ack
- i_data_addr  in  ADDR_W  data byte address
- i_data_wr_en  in  1  1 = store, 0 = load
- i_data_wr_mask  in  4  byte-lane write mask
- i_data_wdata  in  32  store data
- o_data_ack  out  1  one-cycle pulse, data transaction complete
- o_data_rdata  out  32  load data, valid with o_data_ack
- o_mem_req  out  1  memory request, held until i_mem_ack
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wr_en  out  1  memory write enable
- o_mem_wr_mask  out  4  memory byte mask
- o_mem_wdata  out  32  memory write data
- i_mem_ack  in  1  memory completion pulse, latency of 1 or more cycles
- i_mem_rdata  in  32  memory read data, valid with i_mem_ack
- o_grant  out  2  current owner: 00 none, 01 inst, 10 data
- o_busy  out  1  high while the FSM is not in IDLE

Behaviour:
- Clocking and reset: single clock i_clk, synchronous active-high reset i_rst.
- Reset values: state IDLE; o_grant=00; o_busy=0; o_mem_req=0; o_mem_addr=0; o_mem_wr_en=0; o_mem_wr_mask=0; o_mem_wdata=0; both acks 0; both rdata outputs 0; run counter 0.

FSM:
- IDLE: if any request is present, latch the winner's address and controls into the o_mem_* registers, set o_mem_req=1, set o_grant, and go to BUSY. Otherwise stay in IDLE.
- BUSY: hold all o_mem_* outputs stable. On i_mem_ack:
  - clear o_mem_req;
  - capture i_mem_rdata into the winner's rdata register;
  - go to RESP.
- RESP: pulse the winner's ack for exactly one cycle, then go to IDLE with o_grant=00.

Arbitration:
- Fixed priority: data beats inst when both request in the same IDLE cycle.
- A grant is never preempted while in BUSY.

Timing:
- Latency: request sampled at edge N drives o_mem_req from N+1. Memory ack at edge M gives requester ack at M+1.
- Minimum spacing is 3 cycles per transaction; there is no back-to-back issue from RESP.
- A requester may keep req high in the cycle its ack is seen. That level is treated as a new request at the next IDLE.

Data paths:
- Stores: o_data_rdata is updated with i_mem_rdata anyway; its content is don't-care, but the ack is still required.
- Writes from the inst port are impossible: o_mem_wr_en=0 and o_mem_wr_mask=0 for inst grants.
- Addresses pass through unmodified; alignment is the core's job.
- rdata outputs hold their last value between acks.

Error handling:
- i_mem_ack in IDLE or RESP is ignored.
- A requester dropping req while in BUSY has no effect: the transaction completes and the ack is still pulsed.
- Reset while in BUSY or RESP returns to IDLE immediately. No ack is pulsed and o_mem_req drops at that edge.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- When defined: a 3-bit-minimum run counter counts consecutive data grants made while i_inst_req=1.
  - When the count reaches MAX_DATA_RUN, the next IDLE arbitration grants inst even if data is requesting.
  - The counter clears on any inst grant, or on any IDLE cycle with i_inst_req=0.
- When undefined: pure fixed priority and no counter logic; a fetch may starve indefinitely under continuous data traffic.

Test Plan:
1. Single fetch: i_inst_req=1, addr=0x00000010, memory ack 1 cycle after o_mem_req with rdata=0x00A00093 -> o_mem_addr=0x10, o_mem_wr_en=0, o_inst_ack one pulse with o_inst_rdata=0x00A00093, o_grant 01 then 00.
2. Store: i_data_req=1, wr_en=1, mask=0011, addr=0x1080, wdata=0xDEADBEEF, memory latency 3 -> o_mem_* hold for 3 cycles, o_data_ack pulses once, o_inst_ack stays 0.
3. Simultaneous inst (0x20) and data load (0x1084) -> data served first; inst served in the next IDLE; acks in order data then inst, each with its own rdata.
4. Reset asserted while in BUSY, then memory ack arrives -> o_mem_req=0 at the reset edge, no ack pulse, FSM in IDLE, the stray i_mem_ack is ignored.
5. With ARB_STARVE_GUARD_EN, MAX_DATA_RUN=4, continuous data requests plus inst request -> grant sequence D,D,D,D,I,D,... Without the macro -> I never granted over 20 data grants.
6. Spurious i_mem_ack in IDLE with no requests -> no ack outputs, o_busy=0, no state change.
